// File: rtl/seq_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
// Holds the default patterns, the overlap mode flags and the fill-counter width.
package seq_pkg;

  localparam logic [3:0] PAT_1010 = 4'b1010;
  localparam logic [3:0] PAT_1101 = 4'b1101;

  localparam bit OVL_ON  = 1'b1;
  localparam bit OVL_OFF = 1'b0;

  // The fill counter doubles as the detector state: empty, partially filled, armed.
  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILLING,
    ST_ARMED
  } fill_state_t;

  // Bits needed to hold a fill count of 0..n.
  function automatic int fill_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
// Used to count pattern matches since reset.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/seq_detector_param.sv
// Serial MSB-first pattern detector with programmable pattern, overlap mode
// and a saturating match counter; every output is registered.
module seq_detector_param
  import seq_pkg::*;
#(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = PAT_1010,
  parameter bit                     OVERLAP     = OVL_ON,
  parameter int                     CNT_W       = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in,
  input  logic                             in_valid,
  input  logic                             pat_load,
  input  logic [PATTERN_LEN-1:0]           pat_in,
  output logic                             out,
  output logic [CNT_W-1:0]                 match_count,
  output logic [fill_w(PATTERN_LEN)-1:0]   fill
);

  localparam int            FW   = fill_w(PATTERN_LEN);
  localparam logic [FW-1:0] FULL = FW'(PATTERN_LEN);

  logic [PATTERN_LEN-1:0] pat_reg, pat_next;
  logic [PATTERN_LEN-1:0] hist_reg, hist_next;
  logic [FW-1:0]          fill_reg, fill_next;
  logic                   out_reg, out_next;
  logic                   match_inc;

  fill_state_t            state;
  logic [PATTERN_LEN-1:0] shifted;
  logic [FW-1:0]          filled;

  always_comb begin
    state = ST_FILLING;
    if (fill_reg == '0) begin
      state = ST_EMPTY;
    end else if (fill_reg == FULL) begin
      state = ST_ARMED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_reg  <= PATTERN;
      hist_reg <= '0;
      fill_reg <= '0;
      out_reg  <= 1'b0;
    end else begin
      pat_reg  <= pat_next;
      hist_reg <= hist_next;
      fill_reg <= fill_next;
      out_reg  <= out_next;
    end
  end

  always_comb begin
    pat_next  = pat_reg;
    hist_next = hist_reg;
    fill_next = fill_reg;
    out_next  = 1'b0;
    match_inc = 1'b0;
    shifted   = {hist_reg[PATTERN_LEN-2:0], in};

    case (state)
      ST_ARMED: filled = FULL;
      default:  filled = fill_reg + 1'b1;
    endcase

    if (pat_load) begin
      // A new pattern invalidates whatever history was collected against the old one.
      pat_next  = pat_in;
      hist_next = '0;
      fill_next = '0;
    end else if (in_valid) begin
      hist_next = shifted;
      fill_next = filled;
      if ((filled == FULL) && (shifted == pat_reg)) begin
        out_next  = 1'b1;
        match_inc = 1'b1;
        if (!OVERLAP) begin
          hist_next = '0;
          fill_next = '0;
        end
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (match_inc),
    .count (match_count)
  );

  assign out  = out_reg;
  assign fill = fill_reg;

endmodule

// File: tb/tb_seq_detector_param.sv
// Drives three detector variants (overlap, non-overlap, 2-bit counter) with one
// shared stream and checks them every cycle against a stream-level model.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst, in, in_valid, pat_load;
  logic [3:0] pat_in;

  logic       out_a, out_b, out_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic [2:0] fill_a, fill_b, fill_c;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  seq_detector_param #(.PATTERN_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .pat_load(pat_load),
    .pat_in(pat_in), .out(out_a), .match_count(cnt_a), .fill(fill_a));

  seq_detector_param #(.PATTERN_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .pat_load(pat_load),
    .pat_in(pat_in), .out(out_b), .match_count(cnt_b), .fill(fill_b));

  seq_detector_param #(.PATTERN_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .pat_load(pat_load),
    .pat_in(pat_in), .out(out_c), .match_count(cnt_c), .fill(fill_c));

  // Model: every valid bit since the last reset/reload goes into one stream;
  // each variant remembers where its current match window may begin.
  bit         stream[$];
  int         base[3];
  int         mcnt[3];
  bit         mout[3];
  logic [3:0] mpat;
  int         cmax[3] = '{255, 255, 3};
  bit         movl[3] = '{1'b1, 1'b0, 1'b1};

  function automatic int mfill(input int i);
    int avail;
    avail = stream.size() - base[i];
    return (avail > 4) ? 4 : avail;
  endfunction

  always @(posedge clk) begin
    bit ok;
    int sz;
    for (int i = 0; i < 3; i++) mout[i] = 1'b0;
    if (rst) begin
      mpat = 4'b1010;
      stream.delete();
      for (int i = 0; i < 3; i++) begin base[i] = 0; mcnt[i] = 0; end
    end else if (pat_load) begin
      mpat = pat_in;
      stream.delete();
      for (int i = 0; i < 3; i++) base[i] = 0;
    end else if (in_valid) begin
      stream.push_back(in);
      sz = stream.size();
      for (int i = 0; i < 3; i++) begin
        if (sz - base[i] >= 4) begin
          ok = 1'b1;
          for (int k = 0; k < 4; k++)
            if (stream[sz-4+k] != mpat[3-k]) ok = 1'b0;
          if (ok) begin
            mout[i] = 1'b1;
            if (mcnt[i] < cmax[i]) mcnt[i]++;
            if (!movl[i]) base[i] = sz;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a.out", out_a, mout[0]);  chk("a.count", cnt_a, mcnt[0]);  chk("a.fill", fill_a, mfill(0));
      chk("b.out", out_b, mout[1]);  chk("b.count", cnt_b, mcnt[1]);  chk("b.fill", fill_b, mfill(1));
      chk("c.out", out_c, mout[2]);  chk("c.count", cnt_c, mcnt[2]);  chk("c.fill", fill_c, mfill(2));
    end
  end

  task automatic cyc(input bit r, input bit l, input bit v, input bit b, input logic [3:0] p);
    rst = r; pat_load = l; in_valid = v; in = b; pat_in = p;
    @(posedge clk);
    @(negedge clk);
    $display("cyc t=%0t rst=%0b load=%0b vld=%0b in=%0b | a:%0b/%0d/%0d b:%0b/%0d/%0d c:%0b/%0d/%0d",
             $time, r, l, v, b, out_a, cnt_a, fill_a, out_b, cnt_b, fill_b, out_c, cnt_c, fill_c);
  endtask

  task automatic bitv(input bit b);  cyc(1'b0, 1'b0, 1'b1, b, 4'h0);    endtask
  task automatic idle();             cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'h0); endtask
  task automatic reset();            cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'h0); endtask
  task automatic load(input logic [3:0] p); cyc(1'b0, 1'b1, 1'b1, 1'b1, p); endtask
  task automatic send4(input logic [3:0] v);
    for (int k = 3; k >= 0; k--) bitv(v[k]);
  endtask

  initial begin
    rst = 1'b1; in = 1'b0; in_valid = 1'b0; pat_load = 1'b0; pat_in = 4'h0;
    reset();
    chk_en = 1'b1;
    reset();
    chk("rst.out", out_a, 0); chk("rst.count", cnt_a, 0); chk("rst.fill", fill_a, 0);

    // Basic 1010 detection
    bitv(1); bitv(0); bitv(1);
    chk("t1.no_early", out_a, 0);
    bitv(0);
    chk("t1.out", out_a, 1); chk("t1.count", cnt_a, 1); chk("t1.fill", fill_a, 4);
    idle();
    chk("t1.one_cycle", out_a, 0);

    // Overlap vs non-overlap on 101010, then 10 more
    reset();
    send4(4'b1010); bitv(1); bitv(0);
    chk("t2.a_out", out_a, 1);  chk("t2.a_count", cnt_a, 2);
    chk("t3.b_out", out_b, 0);  chk("t3.b_count", cnt_b, 1); chk("t3.b_fill", fill_b, 2);
    bitv(1); bitv(0);
    chk("t3.b_out2", out_b, 1); chk("t3.b_count2", cnt_b, 2);

    // Gaps between valid bits
    reset();
    bitv(1); idle(); bitv(0); idle(); idle(); bitv(1); idle();
    chk("t4.idle_out", out_a, 0);
    bitv(0);
    chk("t4.gap_out", out_a, 1);
    idle();
    chk("t4.gap_after", out_a, 0);

    // Reload pattern 1101
    load(4'b1101);
    chk("t4.load_fill", fill_a, 0); chk("t4.load_count", cnt_a, 1);
    send4(4'b1101);
    chk("t4.new_pat", out_a, 1);
    send4(4'b1010);
    chk("t4.old_pat_a", out_a, 0); chk("t4.old_pat_b", out_b, 0);

    // Reset mid-sequence
    reset();
    bitv(1); bitv(0); bitv(1);
    reset();
    chk("t5.fill", fill_a, 0); chk("t5.out", out_a, 0); chk("t5.count", cnt_a, 0);
    bitv(0);
    chk("t5.zero", out_a, 0);
    send4(4'b1010);
    chk("t5.match", out_a, 1);
    load(4'b1101);
    reset();
    send4(4'b1010);
    chk("t5.restored", out_a, 1);

    // Saturation on the 2-bit counter
    reset();
    bitv(1); bitv(0);
    for (int j = 0; j < 5; j++) begin
      bitv(1); bitv(0);
      chk("t6.c_out", out_c, 1);
      chk("t6.c_count", cnt_c, (j + 1 > 3) ? 3 : j + 1);
    end
    idle();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
